// File: rtl/median_pkg.sv
// Shared constants and types for the 5x5 per-channel median filter.
// Rank width covers 0..24, so one rank value identifies exactly one element.
package median_pkg;
  localparam int KERNEL_N     = 25;
  localparam int CENTRE_IDX   = 12;
  localparam int MEDIAN_RANK  = 12;
  localparam int RANK_W       = 5;
  localparam int PIPE_LATENCY = 4;

  typedef logic [RANK_W-1:0]   rank_t;
  typedef logic [KERNEL_N-1:0] cmp_row_t;
endpackage

// File: rtl/median25_rank.sv
// One colour channel of the median datapath: comparison matrix, rank count, median select.
// Input window is already registered upstream; three further register stages follow here.
module median25_rank
  import median_pkg::*;
#(
  parameter int PX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [KERNEL_N*PX_W-1:0] px,
  input  logic                     bypass,
  input  logic                     zero,
  output logic [PX_W-1:0]          median
);
  localparam int KW = KERNEL_N * PX_W;

  logic [PX_W-1:0] v1 [KERNEL_N];
  logic [PX_W-1:0] v3 [KERNEL_N];
  cmp_row_t        b_d    [KERNEL_N];
  cmp_row_t        b_q    [KERNEL_N];
  rank_t           rank_d [KERNEL_N];
  rank_t           rank_q [KERNEL_N];
  logic [KW-1:0]   px2_q, px3_q;
  logic            bypass2_q, bypass3_q, zero2_q, zero3_q;
  logic [PX_W-1:0] median_d, median_q;

  genvar gi;
  generate
    for (gi = 0; gi < KERNEL_N; gi++) begin : g_unpack
      assign v1[gi] = px[gi*PX_W +: PX_W];
      assign v3[gi] = px3_q[gi*PX_W +: PX_W];
    end
  endgenerate

  // Ties are broken by index so the ranks always form a permutation of 0..24.
  always_comb begin
    for (int i = 0; i < KERNEL_N; i++) begin
      b_d[i] = '0;
      for (int j = 0; j < KERNEL_N; j++) begin
        if (j != i) begin
          b_d[i][j] = (v1[j] < v1[i]) || ((v1[j] == v1[i]) && (j < i));
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < KERNEL_N; i++) begin
      rank_d[i] = rank_t'($countones(b_q[i]));
    end
  end

  always_comb begin
    median_d = '0;
    for (int i = 0; i < KERNEL_N; i++) begin
      if (rank_q[i] == rank_t'(MEDIAN_RANK)) begin
        median_d = median_d | v3[i];
      end
    end
    if (bypass3_q) median_d = v3[CENTRE_IDX];
    if (zero3_q)   median_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < KERNEL_N; i++) begin
        b_q[i]    <= '0;
        rank_q[i] <= '0;
      end
      px2_q     <= '0;
      px3_q     <= '0;
      bypass2_q <= 1'b0;
      bypass3_q <= 1'b0;
      zero2_q   <= 1'b0;
      zero3_q   <= 1'b0;
      median_q  <= '0;
    end else begin
      for (int i = 0; i < KERNEL_N; i++) begin
        b_q[i]    <= b_d[i];
        rank_q[i] <= rank_d[i];
      end
      px2_q     <= px;
      px3_q     <= px2_q;
      bypass2_q <= bypass;
      bypass3_q <= bypass2_q;
      zero2_q   <= zero;
      zero3_q   <= zero2_q;
      median_q  <= median_d;
    end
  end

  assign median = median_q;
endmodule

// File: rtl/median5x5_filter.sv
// 5x5 RGB median filter: pixel position tracking, border pass-through, sync delay line,
// and input registration feeding three per-channel median datapaths.
module median5x5_filter
  import median_pkg::*;
#(
  parameter int PX_W     = 8,
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int CNT_W    = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     filter_en,
  input  logic                     in_dv,
  input  logic                     in_hs,
  input  logic                     in_vs,
  input  logic [KERNEL_N*PX_W-1:0] kernel_red,
  input  logic [KERNEL_N*PX_W-1:0] kernel_green,
  input  logic [KERNEL_N*PX_W-1:0] kernel_blue,
  output logic [PX_W-1:0]          out_red,
  output logic [PX_W-1:0]          out_green,
  output logic [PX_W-1:0]          out_blue,
  output logic                     out_dv,
  output logic                     out_hs,
  output logic                     out_vs
);
  localparam int KW = KERNEL_N * PX_W;
  localparam logic [CNT_W-1:0] EDGE_LO = CNT_W'(2);
  localparam logic [CNT_W-1:0] COL_HI  = CNT_W'(H_ACTIVE - 2);
  localparam logic [CNT_W-1:0] ROW_HI  = CNT_W'(V_ACTIVE - 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]        col_d, col_q, row_d, row_q;
  logic [PIPE_LATENCY-1:0] dv_sr_d, dv_sr_q, hs_sr_d, hs_sr_q, vs_sr_d, vs_sr_q;
  logic                    fen_d, fen_q, border_d, border_q;
  logic                    dv_q, vs_q;
  logic [KW-1:0]           kern_d [3];
  logic [KW-1:0]           kern_q [3];
  logic [PX_W-1:0]         ch_out [3];
  logic                    bypass_s1, zero_s1;

  // Stage 0 of each sync shift register doubles as the S1 copy used for edge detection.
  assign dv_q = dv_sr_q[0];
  assign vs_q = vs_sr_q[0];

  assign kern_d[0] = kernel_red;
  assign kern_d[1] = kernel_green;
  assign kern_d[2] = kernel_blue;

  always_comb begin
    col_d = '0;
    if (in_dv) col_d = (col_q == CNT_MAX) ? col_q : col_q + 1'b1;

    // A vsync rise restarting the frame outranks the end-of-line increment.
    row_d = row_q;
    if (!vs_q && in_vs)
      row_d = '0;
    else if (dv_q && !in_dv && (row_q != CNT_MAX))
      row_d = row_q + 1'b1;

    border_d = (col_q < EDGE_LO) || (col_q >= COL_HI) ||
               (row_q < EDGE_LO) || (row_q >= ROW_HI);
    fen_d    = filter_en;
    dv_sr_d  = {dv_sr_q[PIPE_LATENCY-2:0], in_dv};
    hs_sr_d  = {hs_sr_q[PIPE_LATENCY-2:0], in_hs};
    vs_sr_d  = {vs_sr_q[PIPE_LATENCY-2:0], in_vs};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q    <= '0;
      row_q    <= '0;
      border_q <= 1'b0;
      fen_q    <= 1'b0;
      dv_sr_q  <= '0;
      hs_sr_q  <= '0;
      vs_sr_q  <= '0;
      for (int c = 0; c < 3; c++) kern_q[c] <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      border_q <= border_d;
      fen_q    <= fen_d;
      dv_sr_q  <= dv_sr_d;
      hs_sr_q  <= hs_sr_d;
      vs_sr_q  <= vs_sr_d;
      for (int c = 0; c < 3; c++) kern_q[c] <= kern_d[c];
    end
  end

  assign bypass_s1 = !fen_q || border_q;
  assign zero_s1   = !dv_q;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      median25_rank #(.PX_W(PX_W)) u_rank (
        .clk    (clk),
        .rst    (rst),
        .px     (kern_q[gi]),
        .bypass (bypass_s1),
        .zero   (zero_s1),
        .median (ch_out[gi])
      );
    end
  endgenerate

  assign out_red   = ch_out[0];
  assign out_green = ch_out[1];
  assign out_blue  = ch_out[2];
  assign out_dv    = dv_sr_q[PIPE_LATENCY-1];
  assign out_hs    = hs_sr_q[PIPE_LATENCY-1];
  assign out_vs    = vs_sr_q[PIPE_LATENCY-1];
endmodule

// File: tb/tb_median5x5_filter.sv
// Self-checking bench for median5x5_filter on an 8x8 frame, with a sort-based median
// reference and a 4-deep expected-output queue.
module tb_median5x5_filter;
  localparam int H = 8;
  localparam int V = 8;
  localparam int N = 25;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           filter_en = 1'b0;
  logic           in_dv = 1'b0, in_hs = 1'b0, in_vs = 1'b0;
  logic [N*8-1:0] kernel_red = '0, kernel_green = '0, kernel_blue = '0;
  logic [7:0]     out_red, out_green, out_blue;
  logic           out_dv, out_hs, out_vs;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       dv;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t exp_q[$];
  int   kern [3][N];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  median5x5_filter #(.PX_W(8), .H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(11)) dut (
    .clk          (clk),
    .rst          (rst),
    .filter_en    (filter_en),
    .in_dv        (in_dv),
    .in_hs        (in_hs),
    .in_vs        (in_vs),
    .kernel_red   (kernel_red),
    .kernel_green (kernel_green),
    .kernel_blue  (kernel_blue),
    .out_red      (out_red),
    .out_green    (out_green),
    .out_blue     (out_blue),
    .out_dv       (out_dv),
    .out_hs       (out_hs),
    .out_vs       (out_vs)
  );

  function automatic int median_of(input int c);
    int q[$];
    for (int i = 0; i < N; i++) q.push_back(kern[c][i]);
    q.sort();
    return q[12];
  endfunction

  function automatic bit is_border(input int c, input int r);
    return (c < 2) || (c >= H - 2) || (r < 2) || (r >= V - 2);
  endfunction

  task automatic shuffle(input int c);
    int j;
    int t;
    for (int i = N - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = kern[c][i];
      kern[c][i] = kern[c][j];
      kern[c][j] = t;
    end
  endtask

  // mode 1: 0..24 shuffled; 2: twenty 0x80 + five 0xFF; 3: twelve 0x00 + thirteen 0xFF;
  // 4: centre 0x3C, rest 0; otherwise uniform random.
  task automatic fill_kernel(input int mode);
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) begin
        case (mode)
          1:       kern[c][i] = i;
          2:       kern[c][i] = (i < 20) ? 'h80 : 'hFF;
          3:       kern[c][i] = (i < 12) ? 0 : 'hFF;
          4:       kern[c][i] = (i == 12) ? 'h3C : 0;
          default: kern[c][i] = int'($urandom_range(0, 255));
        endcase
      end
      if (mode >= 1 && mode <= 3) shuffle(c);
    end
  endtask

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 4) begin
      e = exp_q.pop_front();
      check_vec("rgb", {8'h00, out_red, out_green, out_blue}, {8'h00, e.r, e.g, e.b});
      check_vec("sync", {29'h0, out_dv, out_hs, out_vs}, {29'h0, e.dv, e.hs, e.vs});
    end
  endtask

  task automatic pixel(input bit dv, input bit hs, input bit vs, input bit fen,
                       input bit brd, input int mode);
    exp_t e;
    fill_kernel(mode);
    for (int i = 0; i < N; i++) begin
      kernel_red[i*8 +: 8]   = 8'(kern[0][i]);
      kernel_green[i*8 +: 8] = 8'(kern[1][i]);
      kernel_blue[i*8 +: 8]  = 8'(kern[2][i]);
    end
    in_dv = dv;
    in_hs = hs;
    in_vs = vs;
    filter_en = fen;
    e.dv = dv;
    e.hs = hs;
    e.vs = vs;
    if (!dv) begin
      e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
    end else if (!fen || brd) begin
      e.r = 8'(kern[0][12]); e.g = 8'(kern[1][12]); e.b = 8'(kern[2][12]);
    end else begin
      e.r = 8'(median_of(0)); e.g = 8'(median_of(1)); e.b = 8'(median_of(2));
    end
    exp_q.push_back(e);
    tick();
  endtask

  task automatic frame(input int h_len, input int n_lines, input bit send_vs,
                       input bit collide, input int mode, input bit fen_rand);
    bit fen;
    if (send_vs) begin
      pixel(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
      repeat (3) pixel(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
      pixel(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    end
    for (int r = 0; r < n_lines; r++) begin
      for (int c = 0; c < h_len; c++) begin
        fen = fen_rand ? 1'($urandom_range(0, 1)) : (mode != 4);
        pixel(1'b1, 1'b0, 1'b0, fen, is_border(c, r), mode);
      end
      for (int k = 0; k < 3; k++)
        pixel(1'b0, 1'b1, collide && (r == n_lines - 1), 1'b1, 1'b0, 0);
    end
  endtask

  initial begin
    #2;
    check_vec("reset_rgb", {8'h00, out_red, out_green, out_blue}, 32'h0);
    check_vec("reset_sync", {29'h0, out_dv, out_hs, out_vs}, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    frame(H, V, 1'b1, 1'b0, 1, 1'b0);      // shuffled 0..24: interior median 12
    frame(H, V, 1'b1, 1'b0, 2, 1'b0);      // 0x80 majority with 0xFF outliers
    frame(H, V, 1'b1, 1'b0, 3, 1'b0);      // tie-heavy 0x00/0xFF window
    frame(H, V, 1'b1, 1'b0, 4, 1'b0);      // bypass everywhere
    frame(H, V, 1'b1, 1'b0, 0, 1'b1);      // random data, filter_en toggling per pixel
    frame(H + 2, V, 1'b1, 1'b0, 0, 1'b0);  // over-long lines stay border past H-2
    frame(H, 4, 1'b1, 1'b1, 0, 1'b0);      // vs rise coincides with dv fall
    frame(H, V, 1'b0, 1'b0, 0, 1'b0);      // rows must restart at 0 after that collision

    // Reset asserted in the middle of a line.
    pixel(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    pixel(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    for (int c = 0; c < 6; c++) pixel(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    #2 rst = 1'b0;
    #1;
    check_vec("midreset_rgb", {8'h00, out_red, out_green, out_blue}, 32'h0);
    check_vec("midreset_sync", {29'h0, out_dv, out_hs, out_vs}, 32'h0);
    exp_q.delete();
    in_dv = 1'b0;
    in_hs = 1'b0;
    in_vs = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    check_vec("postreset_sync", {29'h0, out_dv, out_hs, out_vs}, 32'h0);

    frame(H, V, 1'b1, 1'b0, 0, 1'b1);
    repeat (4) pixel(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
